// File: rtl/regfile_pkg.sv
// Shared register-file parameters and helpers for the decode and writeback stages.
// Holds only constants, typedefs and elaboration-time functions; there is no logic here.
package regfile_pkg;

  localparam int DEF_DATA_W   = 8;
  localparam int DEF_NUM_REGS = 8;
  localparam int DEF_NUM_RD   = 3;
  localparam int DEF_NUM_WR   = 2;
  localparam int DEF_BYPASS   = 1;
  localparam int DEF_READ_LAT = 0;
  localparam int MAX_RD       = 4;
  localparam int MAX_WR       = 2;

  // Address width, never allowed to collapse to zero bits.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic bit is_pow2(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

  typedef logic [DEF_DATA_W-1:0]                 def_data_t;
  typedef logic [clog2_min1(DEF_NUM_REGS)-1:0]   def_addr_t;

endpackage

// File: rtl/regfile_read_port.sv
// One read port: address mux, write bypass and optional output register.
// Latency 0 (combinational) or 1 (write-first registered); no backpressure, always ready.
module regfile_read_port import regfile_pkg::*; #(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int NUM_WR   = DEF_NUM_WR,
  parameter int BYPASS   = DEF_BYPASS,
  parameter int READ_LAT = DEF_READ_LAT,
  localparam int AW      = clog2_min1(NUM_REGS)
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     clear,
  input  logic [AW-1:0]            rd_addr,
  input  logic [DATA_W-1:0]        regs [NUM_REGS],
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*AW-1:0]     wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0]        rd_data
);

  logic [DATA_W-1:0] stored;
  logic [DATA_W-1:0] fwd;
  logic [DATA_W-1:0] comb_data;
  logic [DATA_W-1:0] rd_q;

  // fwd is the value the register will hold after this edge (ignoring clear);
  // ports are scanned high to low so port 0 wins a collision.
  always_comb begin
    stored = regs[rd_addr];
    fwd    = stored;
    for (int k = NUM_WR - 1; k >= 0; k--) begin
      if (wr_en[k] && (wr_addr[k*AW +: AW] == rd_addr) && (rd_addr != '0)) begin
        fwd = wr_data[k*DATA_W +: DATA_W];
      end
    end
    comb_data = ((BYPASS != 0) && !clear) ? fwd : stored;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_q <= '0;
    end else begin
      rd_q <= clear ? '0 : fwd;
    end
  end

  assign rd_data = (READ_LAT != 0) ? rd_q : comb_data;

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file with r0 hardwired to zero, port-0-priority writes and conflict flag.
// Read latency 0 or 1 per READ_LAT; writes always accepted, no backpressure.
module register_file_mp import regfile_pkg::*; #(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int NUM_WR   = DEF_NUM_WR,
  parameter int BYPASS   = DEF_BYPASS,
  parameter int READ_LAT = DEF_READ_LAT,
  localparam int AW      = clog2_min1(NUM_REGS)
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     clear,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*AW-1:0]     wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  output logic                     wr_conflict
);

  if (NUM_WR < 1 || NUM_WR > MAX_WR) begin : g_bad_wr
    $fatal(1, "register_file_mp: NUM_WR must be 1..%0d", MAX_WR);
  end
  if (NUM_RD < 1 || NUM_RD > MAX_RD) begin : g_bad_rd
    $fatal(1, "register_file_mp: NUM_RD must be 1..%0d", MAX_RD);
  end
  if (!is_pow2(NUM_REGS)) begin : g_bad_regs
    $fatal(1, "register_file_mp: NUM_REGS must be a power of two >= 2");
  end
  if (READ_LAT < 0 || READ_LAT > 1) begin : g_bad_lat
    $fatal(1, "register_file_mp: READ_LAT must be 0 or 1");
  end

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              conflict_nxt;

  // Entry 0 is only ever reset, so it reads as zero without a special read path.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
    end else if (clear) begin
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
    end else begin
      for (int k = NUM_WR - 1; k >= 0; k--) begin
        if (wr_en[k] && (wr_addr[k*AW +: AW] != '0)) begin
          regs[wr_addr[k*AW +: AW]] <= wr_data[k*DATA_W +: DATA_W];
        end
      end
    end
  end

  if (NUM_WR == 2) begin : g_conflict
    assign conflict_nxt = wr_en[0] && wr_en[1] &&
                          (wr_addr[0 +: AW] == wr_addr[AW +: AW]) &&
                          (wr_addr[0 +: AW] != '0);
  end else begin : g_no_conflict
    assign conflict_nxt = 1'b0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_conflict <= 1'b0;
    end else begin
      wr_conflict <= conflict_nxt;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    regfile_read_port #(
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS),
      .NUM_WR   (NUM_WR),
      .BYPASS   (BYPASS),
      .READ_LAT (READ_LAT)
    ) u_port (
      .clock   (clock),
      .reset_n (reset_n),
      .clear   (clear),
      .rd_addr (rd_addr[i*AW +: AW]),
      .regs    (regs),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_data (rd_data[i*DATA_W +: DATA_W])
    );
  end

endmodule
